merged_pe_stage_sched: RTL

- Sequences one decoding stage of the polar SC decoder through a single shared merged PE.
- On start, streams P LLR pairs from the stage LLR memory into the PE.
- Selects the f or g result per pair and writes it to the next-stage LLR buffer.
- Sits between the LLR memories and the merged PE instance; the top-level decoder FSM issues start per stage and waits on done.

---
 rtl/merged_pe_stage_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/merged_pe_stage_sched.sv
// Stage scheduler for the polar SC decoder: streams P LLR pairs through one
// shared merged PE and writes the mode/psum-selected result to the next stage.
module merged_pe_stage_sched #(
    parameter int W     = 9,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] num_pairs,
    output logic             rd_en,
    output logic [LEN_W-1:0] rd_addr,
    input  logic [W-1:0]     rd_data_a,
    input  logic [W-1:0]     rd_data_b,
    input  logic             rd_psum,
    output logic [W-1:0]     pe_in1,
    output logic [W-1:0]     pe_in2,
    input  logic [W-1:0]     pe_out1,
    input  logic [W-1:0]     pe_out2,
    input  logic [W-1:0]     pe_out3,
    output logic             wr_en,
    output logic [LEN_W-1:0] wr_addr,
    output logic [W-1:0]     wr_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t           r_state;
    logic             r_mode;
    logic [LEN_W-1:0] r_last;
    logic             r_rd_en;
    logic [LEN_W-1:0] r_rd_addr;
    logic             r_busy;
    logic             r_done;

    logic             r_s1_vld;
    logic [LEN_W-1:0] r_s1_addr;
    logic             r_pe_vld;
    logic [LEN_W-1:0] r_pe_addr;
    logic [W-1:0]     r_pe_in1;
    logic [W-1:0]     r_pe_in2;
    logic             r_psum;
    logic             r_wr_en;
    logic [LEN_W-1:0] r_wr_addr;
    logic [W-1:0]     r_wr_data;

    logic             w_stall;
    logic             w_empty;
    logic [W-1:0]     w_sel;

    assign w_stall = r_wr_en & ~out_ready;
    // Pipeline drains this cycle: nothing in flight and the last write (if any) transfers now.
    assign w_empty = ~r_rd_en & ~r_s1_vld & ~r_pe_vld & ~w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= 1'b0;
            r_last    <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mode    <= mode;
                        r_last    <= num_pairs - 1'b1;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        // P=0 passes through DRAIN so busy is visible for one cycle before done.
                        if (num_pairs != '0) begin
                            r_rd_en <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                RUN: begin
                    if (!w_stall) begin
                        if (r_rd_addr == r_last) begin
                            r_rd_en <= 1'b0;
                            r_state <= DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_sel = pe_out1;
        if (r_mode) w_sel = r_psum ? pe_out3 : pe_out2;
    end

    // The memory holds its data while rd_en is low, so S1 may capture after a stall ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_pe_vld  <= 1'b0;
            r_pe_addr <= '0;
            r_pe_in1  <= '0;
            r_pe_in2  <= '0;
            r_psum    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (!w_stall) begin
            r_s1_vld  <= r_rd_en;
            r_s1_addr <= r_rd_addr;
            r_pe_vld  <= r_s1_vld;
            if (r_s1_vld) begin
                r_pe_in1  <= rd_data_a;
                r_pe_in2  <= rd_data_b;
                r_psum    <= rd_psum;
                r_pe_addr <= r_s1_addr;
            end
            r_wr_en <= r_pe_vld;
            if (r_pe_vld) begin
                r_wr_addr <= r_pe_addr;
                r_wr_data <= w_sel;
            end
        end
    end

    assign rd_en   = r_rd_en & ~w_stall;
    assign rd_addr = r_rd_addr;
    assign pe_in1  = r_pe_in1;
    assign pe_in2  = r_pe_in2;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
